// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: state encoding,
// word geometry, default terminating word and a ceil-log2 helper.
package instr_loader_pkg;

    // State encoding
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_RECV_ENC  = 3'd1;
    localparam logic [2:0] ST_WRITE_ENC = 3'd2;
    localparam logic [2:0] ST_CHECK_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RECV  = ST_RECV_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_CHECK = ST_CHECK_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Ceiling log2; clogb2(1) = 0, clogb2(2048) = 11, clogb2(4) = 2
    function automatic int clogb2(input int value);
        int v;
        int r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Shifts UART bytes MSB-first into a word, counts bytes within the word and
// flags (one cycle late, registered) that a full word has been assembled.
module instr_loader_word_assembler
    import instr_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          accept,
    input  logic [7:0]                    rx_byte,
    output logic [BYTES_PER_WORD*8-1:0]   word,
    output logic [BYTE_CNT_W-1:0]         byte_cnt,
    output logic                          word_valid
);

    localparam int WORD_W = BYTES_PER_WORD * 8;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0]     word_reg;
    logic [WORD_W-1:0]     word_next;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic                  word_valid_reg;

    // Byte lanes: the new byte enters lane 0, every other lane takes its lower neighbour
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign word_next[7:0] = rx_byte;
            end else begin : g_shift
                assign word_next[gi*8 +: 8] = word_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    // Shift register, byte counter and the completed-word pulse
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_reg       <= '0;
            byte_cnt_reg   <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= accept && (byte_cnt_reg == LAST_BYTE);
            if (accept) begin
                word_reg     <= word_next;
                byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
            end
        end
    end

    assign word       = word_reg;
    assign byte_cnt   = byte_cnt_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/instr_loader.sv
// Boot loader in front of the instruction RAM write port. Builds 32-bit words
// from the UART byte stream and writes them from address 0 upward until the
// HALT word is seen or the RAM is full.
// Optional checksum byte after HALT: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int                    RAM_WIDTH = 32,
    parameter int                    RAM_DEPTH = 2048,
    parameter logic [RAM_WIDTH-1:0]  HALT_WORD = RAM_WIDTH'(DEFAULT_HALT_WORD)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_done,
    output logic [RAM_WIDTH-1:0]          o_addr,
    output logic [RAM_WIDTH-1:0]          o_data,
    output logic                          o_we,
    output logic                          o_en,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_full,
    output logic                          o_error,
    output logic [clogb2(RAM_DEPTH):0]    o_word_count
);

    localparam int IDX_W  = (clogb2(RAM_DEPTH) < 1) ? 1 : clogb2(RAM_DEPTH);
    localparam int CNT_W  = clogb2(RAM_DEPTH) + 1;
    localparam int WORD_W = BYTES_PER_WORD * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

    state_t                state_reg;
    logic [IDX_W-1:0]      word_idx_reg;
    logic [CNT_W-1:0]      word_count_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  full_reg;

    logic [WORD_W-1:0]     asm_word;
    logic [BYTE_CNT_W-1:0] asm_byte_cnt;
    logic                  asm_word_valid;
    logic [RAM_WIDTH-1:0]  cur_word;

    logic                  start_accept;
    logic                  last_write;
    logic                  asm_accept;
    logic                  fourth_byte;

    assign cur_word     = RAM_WIDTH'(asm_word);
    assign start_accept = i_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // The write in progress ends the load; a byte arriving alongside it is not data
    assign last_write   = (cur_word == HALT_WORD) || (word_idx_reg == LAST_IDX);
    assign asm_accept   = i_rx_done && ((state_reg == ST_RECV) ||
                                        ((state_reg == ST_WRITE) && !last_write));
    assign fourth_byte  = asm_accept && (asm_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    instr_loader_word_assembler u_word_assembler (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (start_accept),
        .accept     (asm_accept),
        .rx_byte    (i_rx_data),
        .word       (asm_word),
        .byte_cnt   (asm_byte_cnt),
        .word_valid (asm_word_valid)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic       error_reg;
    logic [7:0] csum_reg;

    // Running XOR of every data byte taken into this load
    always_ff @(posedge i_clk) begin
        if (i_reset || start_accept) begin
            csum_reg <= 8'h00;
        end else if (asm_accept) begin
            csum_reg <= csum_reg ^ i_rx_data;
        end
    end
`endif

    // Load sequencing, word addressing and status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= ST_IDLE;
            word_idx_reg   <= '0;
            word_count_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            full_reg       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            error_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_reg      <= ST_RECV;
                        word_idx_reg   <= '0;
                        word_count_reg <= '0;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        full_reg       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        error_reg      <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (fourth_byte) begin
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    word_count_reg <= word_count_reg + CNT_W'(1);
                    if (cur_word == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_reg <= ST_CHECK;
`else
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end else if (word_idx_reg == LAST_IDX) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        full_reg  <= 1'b1;
                    end else begin
                        word_idx_reg <= word_idx_reg + IDX_W'(1);
                        state_reg    <= ST_RECV;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_done) begin
                        error_reg <= (i_rx_data != csum_reg);
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_addr       = RAM_WIDTH'(word_idx_reg);
    assign o_data       = cur_word;
    assign o_we         = asm_word_valid;
    assign o_en         = asm_word_valid;
    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_full       = full_reg;
    assign o_word_count = word_count_reg;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign o_error      = error_reg;
`else
    assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a default-depth instance for the
// general loads and a depth-4 instance for the memory-full stop.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int CW_B = clogb2(2048) + 1;
    localparam int CW_S = clogb2(4) + 1;

    logic clk;
    logic rst;
    logic start;
    logic rx_done;
    logic [7:0] rx_data;
    logic sel;    // 0: stimulus to the default instance, 1: to the small one

    logic start_b, rx_done_b, start_s, rx_done_s;
    assign start_b   = start   & ~sel;
    assign rx_done_b = rx_done & ~sel;
    assign start_s   = start   &  sel;
    assign rx_done_s = rx_done &  sel;

    logic [31:0]     addr_b, data_b, addr_s, data_s;
    logic            we_b, en_b, busy_b, done_b, full_b, err_b;
    logic            we_s, en_s, busy_s, done_s, full_s, err_s;
    logic [CW_B-1:0] wc_b;
    logic [CW_S-1:0] wc_s;

    instr_loader u_dut_big (
        .i_clk(clk), .i_reset(rst), .i_start(start_b),
        .i_rx_data(rx_data), .i_rx_done(rx_done_b),
        .o_addr(addr_b), .o_data(data_b), .o_we(we_b), .o_en(en_b),
        .o_busy(busy_b), .o_done(done_b), .o_full(full_b), .o_error(err_b),
        .o_word_count(wc_b)
    );

    instr_loader #(.RAM_DEPTH(4)) u_dut_small (
        .i_clk(clk), .i_reset(rst), .i_start(start_s),
        .i_rx_data(rx_data), .i_rx_done(rx_done_s),
        .o_addr(addr_s), .o_data(data_s), .o_we(we_s), .o_en(en_s),
        .o_busy(busy_s), .o_done(done_s), .o_full(full_s), .o_error(err_s),
        .o_word_count(wc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q_b[$];
    wr_t q_s[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Scoreboard: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write_big: addr %h data %h, no write expected", addr_b, data_b);
            end else begin
                wr_t e;
                e = q_b.pop_front();
                $display("big write addr=%h data=%h (want %h/%h)", addr_b, data_b, e.addr, e.data);
                check("wr_addr_big", addr_b, e.addr);
                check("wr_data_big", data_b, e.data);
                check("wr_en_big", {31'd0, en_b}, 32'd1);
            end
        end
        if (we_s === 1'b1) begin
            if (q_s.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write_small: addr %h data %h, no write expected", addr_s, data_s);
            end else begin
                wr_t e;
                e = q_s.pop_front();
                $display("small write addr=%h data=%h (want %h/%h)", addr_s, data_s, e.addr, e.data);
                check("wr_addr_small", addr_s, e.addr);
                check("wr_data_small", data_s, e.data);
                check("wr_en_small", {31'd0, en_s}, 32'd1);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        tick(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], gap);
    endtask

    task automatic push_b(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q_b.push_back(e);
    endtask

    task automatic push_s(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q_s.push_back(e);
    endtask

    task automatic wait_done_b(input string name);
        for (int i = 0; i < 40 && done_b !== 1'b1; i++) tick(1);
        check(name, {31'd0, done_b}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},  addr_b, 32'd0);
        check({tag, "_data"},  data_b, 32'd0);
        check({tag, "_we"},    {31'd0, we_b}, 32'd0);
        check({tag, "_en"},    {31'd0, en_b}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_b}, 32'd0);
        check({tag, "_done"},  {31'd0, done_b}, 32'd0);
        check({tag, "_full"},  {31'd0, full_b}, 32'd0);
        check({tag, "_error"}, {31'd0, err_b}, 32'd0);
        check({tag, "_count"}, 32'(wc_b), 32'd0);
    endtask

    typedef struct {
        logic [31:0] bytes_in;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{bytes_in: 32'h0000_000A, exp_data: 32'h0000_000A};
        vecs[1] = '{bytes_in: 32'h8C01_0004, exp_data: 32'h8C01_0004};
        vecs[2] = '{bytes_in: 32'hFFFF_FFFF, exp_data: 32'hFFFF_FFFF};

        rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00; sel = 1'b0;
        tick(1);
        do_reset();
        check_idle_outputs("reset");
        check("reset_small_count", 32'(wc_s), 32'd0);

        // Bytes with no start are ignored
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1);
        tick(2);
        check("prestart_busy", {31'd0, busy_b}, 32'd0);
        check("prestart_done", {31'd0, done_b}, 32'd0);
        check("prestart_count", 32'(wc_b), 32'd0);

        // Table-driven basic load
        pulse_start();
        check("start_busy", {31'd0, busy_b}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            push_b(32'(i), vecs[i].exp_data);
            send_word(vecs[i].bytes_in, 1);
        end
        wait_done_b("basic_done");
        check("basic_count", 32'(wc_b), 32'd3);
        check("basic_full", {31'd0, full_b}, 32'd0);
        check("basic_busy", {31'd0, busy_b}, 32'd0);
        check("basic_error", {31'd0, err_b}, 32'd0);
        check("basic_pending", 32'(q_b.size()), 32'd0);

        // Restart from DONE; a start pulse mid-word is ignored
        pulse_start();
        check("restart_done_clr", {31'd0, done_b}, 32'd0);
        check("restart_count_clr", 32'(wc_b), 32'd0);
        push_b(32'd0, 32'hFFFF_FFFE);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 1);
        pulse_start();
        send_byte(8'hFF, 1);
        send_byte(8'hFE, 1);
        push_b(32'd1, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1);
        wait_done_b("restart_done");
        check("restart_count", 32'(wc_b), 32'd2);
        check("restart_pending", 32'(q_b.size()), 32'd0);

        // Reset mid-word aborts without a write
        do_reset();
        pulse_start();
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        do_reset();
        check_idle_outputs("midreset");
        pulse_start();
        push_b(32'd0, 32'h1234_5678);
        send_word(32'h1234_5678, 1);
        tick(2);
        check("midreset_pending", 32'(q_b.size()), 32'd0);
        check("midreset_count", 32'(wc_b), 32'd1);
        check("midreset_busy", {31'd0, busy_b}, 32'd1);

        // Byte arriving in the WRITE cycle starts the next word
        do_reset();
        pulse_start();
        push_b(32'd0, 32'h1122_3344);
        push_b(32'd1, 32'hABCD_EF01);
        send_word(32'h1122_3344, 0);
        send_byte(8'hAB, 1);
        send_byte(8'hCD, 1);
        send_byte(8'hEF, 1);
        send_byte(8'h01, 1);
        tick(2);
        check("b2b_pending", 32'(q_b.size()), 32'd0);
        check("b2b_count", 32'(wc_b), 32'd2);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // HALT-only load, checksum byte correct then wrong
        do_reset();
        pulse_start();
        push_b(32'd0, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1);
        tick(2);
        check("csum_wait_busy", {31'd0, busy_b}, 32'd1);
        check("csum_wait_done", {31'd0, done_b}, 32'd0);
        send_byte(8'h00, 1);
        wait_done_b("csum_ok_done");
        check("csum_ok_error", {31'd0, err_b}, 32'd0);
        pulse_start();
        push_b(32'd0, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1);
        send_byte(8'h01, 1);
        wait_done_b("csum_bad_done");
        check("csum_bad_error", {31'd0, err_b}, 32'd1);
        check("csum_pending", 32'(q_b.size()), 32'd0);
`endif

        // Memory-full stop on the depth-4 instance
        do_reset();
        sel = 1'b1;
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            logic [31:0] word;
            for (int j = 0; j < 4; j++) word[(3-j)*8 +: 8] = 8'(4*w + j + 1);
            push_s(32'(w), word);
            send_word(word, 1);
        end
        for (int i = 0; i < 40 && done_s !== 1'b1; i++) tick(1);
        check("full_done", {31'd0, done_s}, 32'd1);
        check("full_flag", {31'd0, full_s}, 32'd1);
        check("full_count", 32'(wc_s), 32'd4);
        check("full_busy", {31'd0, busy_s}, 32'd0);
        send_byte(8'h11, 1);
        tick(2);
        check("full_extra_count", 32'(wc_s), 32'd4);
        check("full_extra_done", {31'd0, done_s}, 32'd1);
        check("full_pending", 32'(q_s.size()), 32'd0);
        sel = 1'b0;

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
